// File: rtl/dff_arb_pkg.sv
// Shared definitions for the DFF bank arbiter.
//   arb_state_e : arbiter FSM state encoding (idle, single grant, locked burst)
//   LOCK_CNT_W  : width of the burst-length counter (holds up to 15)
package dff_arb_pkg;

  localparam int unsigned LOCK_CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StLock  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Scans req upward from ptr, wrapping modulo N_REQ, and returns the first set bit.
//   req : request vector
//   ptr : index with highest priority
//   win : one-hot winner (all zero when nothing requests)
//   any : at least one request present
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic             any
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = PTR_W'((32'(ptr) + i) % N_REQ);
      if (!any && req[idx]) begin
        win[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter for a shared DATA_W-bit holding register.
// A granted requester asserting lock may keep the bank for up to LOCK_MAX
// consecutive writes; otherwise the bank rotates one write per requester.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester write request
//   lock       : per-requester burst request (honoured only for the owner)
//   wr_data    : packed write data, requester i at [i*DATA_W +: DATA_W]
//   gnt        : registered one-hot grant, aligned with the write on q
//   q          : shared register
//   q_vld      : q was written at the preceding edge
//   q_par      : even parity of q (only when DFF_ARB_PARITY_EN is defined)
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ*DATA_W-1:0] wr_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]       q,
`ifdef DFF_ARB_PARITY_EN
  output logic                    q_par,
`endif
  output logic                    q_vld
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  arb_state_e            state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      owner_q, owner_d;
  logic [LOCK_CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]     q_q, q_d;
  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic                  vld_q, vld_d;
  // Low for the first edge after reset release so the first grant lands on the second edge.
  logic                  armed_q;

  logic [DATA_W-1:0] data_arr [N_REQ];
  logic [PTR_W-1:0]  next_owner, arb_ptr, win_idx;
  logic [N_REQ-1:0]  win;
  logic              any, hold;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      data_arr[i] = wr_data[i*DATA_W +: DATA_W];
    end
  end

  assign next_owner = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
  // Leaving a grant moves priority just past the owner in the same cycle.
  assign arb_ptr    = (state_q == StIdle) ? ptr_q : next_owner;
  assign hold       = (state_q == StLock) && req[owner_q] && lock[owner_q] &&
                      (cnt_q < LOCK_CNT_W'(LOCK_MAX));

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req (req),
    .ptr (arb_ptr),
    .win (win),
    .any (any)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win[i]) win_idx = PTR_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    gnt_d   = '0;
    vld_d   = 1'b0;
    if (hold) begin
      q_d   = data_arr[owner_q];
      gnt_d = gnt_q;
      vld_d = 1'b1;
      cnt_d = cnt_q + LOCK_CNT_W'(1);
    end else begin
      if (state_q != StIdle) ptr_d = arb_ptr;
      if (any && armed_q) begin
        owner_d = win_idx;
        q_d     = data_arr[win_idx];
        gnt_d   = win;
        vld_d   = 1'b1;
        cnt_d   = LOCK_CNT_W'(1);
        state_d = lock[win_idx] ? StLock : StGrant;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      armed_q <= 1'b1;
    end
  end

  assign q     = q_q;
  assign gnt   = gnt_q;
  assign q_vld = vld_q;

`ifdef DFF_ARB_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^q_d;
    end
  end

  assign q_par = par_q;
`endif

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Scoreboard bench for dff_bank_arbiter: the driver computes each edge's expected
// outputs from a behavioural model and queues them; the monitor pops and compares.
module tb_dff_bank_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int LM = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req, lock;
  logic [N*W-1:0] wr_data;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           q_vld;
`ifdef DFF_ARB_PARITY_EN
  logic           q_par;
`endif

  always #5 clk = ~clk;

  dff_bank_arbiter #(
    .N_REQ    (N),
    .DATA_W   (W),
    .LOCK_MAX (LM)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .lock    (lock),
    .wr_data (wr_data),
    .gnt     (gnt),
    .q       (q),
`ifdef DFF_ARB_PARITY_EN
    .q_par   (q_par),
`endif
    .q_vld   (q_vld)
  );

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [W-1:0] q;
    logic         vld;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Model state: mode 0 = bank free, 1 = single write done, 2 = burst in progress.
  int         m_mode, m_owner, m_ptr, m_cnt;
  bit         m_live;
  logic [W-1:0] m_q;

  task automatic model_reset();
    m_mode  = 0;
    m_owner = 0;
    m_ptr   = 0;
    m_cnt   = 0;
    m_live  = 1'b0;
    m_q     = '0;
  endtask

  // Apply inputs for the coming edge and queue what that edge must produce.
  task automatic issue(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N*W-1:0] d);
    exp_t e;
    int   start;
    int   w;
    req     = r;
    lock    = l;
    wr_data = d;
    e.gnt   = '0;
    e.vld   = 1'b0;
    if (m_mode == 2 && r[m_owner] && l[m_owner] && m_cnt < LM) begin
      m_cnt++;
      m_q            = d[m_owner*W +: W];
      e.gnt[m_owner] = 1'b1;
      e.vld          = 1'b1;
    end else begin
      start = (m_mode == 0) ? m_ptr : (m_owner + 1) % N;
      m_ptr = start;
      w     = -1;
      for (int i = 0; i < N; i++) begin
        if (w < 0 && r[(start + i) % N]) w = (start + i) % N;
      end
      if (w >= 0 && m_live) begin
        m_owner  = w;
        m_cnt    = 1;
        m_q      = d[w*W +: W];
        e.gnt[w] = 1'b1;
        e.vld    = 1'b1;
        m_mode   = l[w] ? 2 : 1;
      end else begin
        m_mode = 0;
      end
    end
    e.q    = m_q;
    m_live = 1'b1;
    sb.push_back(e);
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N*W-1:0] d);
    @(negedge clk);
    #1;
    issue(r, l, d);
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (!rst_n) begin
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_q", 32'(q), 0);
        chk("rst_q_vld", 32'(q_vld), 0);
`ifdef DFF_ARB_PARITY_EN
        chk("rst_q_par", 32'(q_par), 0);
`endif
      end else if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("gnt", 32'(gnt), 32'(e.gnt));
        chk("q", 32'(q), 32'(e.q));
        chk("q_vld", 32'(q_vld), 32'(e.vld));
`ifdef DFF_ARB_PARITY_EN
        chk("q_par", 32'(q_par), 32'(^e.q));
`endif
      end
    end
  end

  initial begin : driver
    logic [N-1:0] r, l;
    model_reset();
    rst_n   = 1'b0;
    req     = 4'hf;
    lock    = '0;
    wr_data = '0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    // First edge after release never grants.
    issue(4'hf, 4'h0, 32'h44332211);
    // Round robin: 0,1,2,3,0.
    repeat (5) step(4'hf, 4'h0, 32'h44332211);
    repeat (2) step(4'h0, 4'h0, $urandom);
    // Burst limit with a competing requester 0.
    repeat (7) step(4'b0101, 4'b0100, $urandom);
    repeat (2) step(4'h0, 4'h0, $urandom);
    // Early lock release with requester 3 waiting.
    repeat (2) step(4'b1010, 4'b0010, $urandom);
    repeat (2) step(4'b1010, 4'b0000, $urandom);
    repeat (2) step(4'h0, 4'h0, $urandom);
    // Reset pulsed in the middle of a burst.
    repeat (2) step(4'b0100, 4'b0100, $urandom);
    #2;
    rst_n = 1'b0;
    sb.delete();
    model_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    issue(4'hf, 4'h0, $urandom);
    repeat (3) step(4'hf, 4'h0, $urandom);
    // Randomised traffic, lock mostly held so bursts reach the limit.
    repeat (400) begin
      r = 4'($urandom);
      l = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hf;
      step(r, l, $urandom);
    end
    repeat (2) step(4'h0, 4'h0, $urandom);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Round-robin write arbiter for the shared D-flip-flop holding register used by the home-automation control path. Up to `N_REQ` requesters compete to load a `DATA_W`-bit word into one register bank `q`. One requester may hold the bank for a bounded burst of consecutive writes. The block sits between the sensor and actuator requesters and the single state register they share.

## Interface
- `N_REQ`, 4: number of requesters, from 2 to 8.
- `DATA_W`, 8: width of the shared register.
- `LOCK_MAX`, 4: maximum consecutive writes by one locked requester, from 1 to 15.
- `clk` in 1: the block's single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req` in `N_REQ`: per-requester write request, level-sensitive.
- `lock` in `N_REQ`: per-requester burst request; only meaningful while that requester is granted.
- `wr_data` in `N_REQ*DATA_W`: write data; requester i drives bits `[i*DATA_W +: DATA_W]`.
- `gnt` out `N_REQ`: registered one-hot grant. High in the cycle its write is visible on `q`.
- `q` out `DATA_W`: shared register contents.
- `q_vld` out 1: high in any cycle in which `q` was updated at the preceding edge.
- `q_par` out 1: even parity of `q`. Present only when `DFF_ARB_PARITY_EN` is defined.

## Operation
- **Reset values:** `q`=0, `gnt`=0, `q_vld`=0, `q_par`=0, state=IDLE, rr pointer=0, lock counter=0.
- **States:** IDLE, GRANT, LOCK.
- **IDLE:**
  - No `req` bit set: stay in IDLE.
  - Otherwise: the winner is the first set `req` bit scanning upward from the rr pointer, wrapping modulo `N_REQ`.
  - At the edge: `q`<=winner's data, `gnt`<=onehot(winner), `q_vld`<=1.
  - Next state is LOCK if `lock[winner]`=1, else GRANT. Lock counter<=1.
- **GRANT (single write done):**
  - rr pointer<=(owner+1) mod `N_REQ`.
  - Arbitrate exactly as in IDLE, using the updated pointer, in this same cycle. Back-to-back writes by different requesters therefore cost no idle cycle.
  - No `req` set: go to IDLE with `gnt`=0 and `q_vld`=0.
- **LOCK:**
  - Continue while `req[owner]`=1, `lock[owner]`=1 and lock counter<`LOCK_MAX`. Each cycle: `q`<=owner's data, `gnt` stays on the owner, `q_vld`=1, counter increments.
  - Any of those conditions false: act exactly as GRANT (advance pointer past owner, re-arbitrate).
- Requesters other than the owner are ignored while LOCK is held.
- A `lock` bit on a non-granted requester has no effect.
- **Counter wrap:** the lock counter saturates at `LOCK_MAX`; it never wraps.
- **Release at the limit:** when the counter reaches `LOCK_MAX`, the owner loses the bank even if it still asserts `lock`. It competes again from the lowest priority.
- **Simultaneous request and release:** when the owner drops `req` in the same cycle another requester raises `req`, the other requester wins at that edge.
- **Reset mid-burst:** `rst_n` low clears all state immediately. `q` returns to 0 even mid-burst.

## Timing
- **Latency:** `req` high in cycle c gives `gnt` and the new `q` in cycle c+1 (one edge).
- **Sustained throughput:** one write per cycle.
- **Dropping `req`:**
  - A requester that sees its `gnt` and wants no further write must drop `req` in that same cycle.
  - A non-locked requester that keeps `req` high is re-queued behind the others.
- `wr_data` is sampled only at the winning edge.
- **Reset release:** first grant at the second rising edge after `rst_n` deasserts.

## Configuration
- **`DFF_ARB_PARITY_EN` defined:**
  - Adds output `q_par`, a register updated in the same edge as `q`, equal to the XOR of the next `q`.
  - Reset value 0.
- **Undefined:** the `q_par` port and its flop do not exist. All other behaviour is identical.

## Structure
- Shared package `dff_arb_pkg` holds:
  - the state enum (IDLE=2'd0, GRANT=2'd1, LOCK=2'd2);
  - the `LOCK_CNT_W`=4 constant.
- One sub-module, `rr_pick`: a combinational round-robin selector taking `req` and the pointer and returning a one-hot winner plus an `any` flag.
- The state machine, lock counter and `q` register stay in the top module.

## Test plan
- **Reset:** hold `rst_n`=0, drive `req`=4'b1111 -> `q`=0, `gnt`=0, `q_vld`=0 throughout; first `gnt`=4'b0001 at the second edge after release.
- **Round-robin:** constant `req`=4'b1111, `lock`=0, `wr_data` = {8'h44, 8'h33, 8'h22, 8'h11} (requester 3 down to 0) -> `gnt` sequence 0001, 0010, 0100, 1000, 0001, with `q` = 11, 22, 33, 44, 11 on consecutive cycles.
- **Burst limit:** requester 2 holds `req` and `lock` with `LOCK_MAX`=4 and `req[0]`=1 -> `gnt`=0100 for exactly 4 cycles, then 0001.
- **Early release:** requester 1 drops `lock` after 2 writes while `req[3]`=1 -> `gnt` 0010, 0010, 1000.
- **Reset mid-burst:** `rst_n` pulsed low during a LOCK -> `q`, `gnt` and `q_vld` go to 0 asynchronously; the pointer restarts at requester 0.
- **Parity (with `DFF_ARB_PARITY_EN`):** `q`=8'h07 -> `q_par`=1; `q`=8'h03 -> `q_par`=0.
